alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Initiator-side front end for the 4-bit ALU datapath. It accepts MIPS-style R-type commands (6-bit funct plus two 4-bit operands) over a valid/ready handshake and decodes funct into the ALU's 3-bit Operation code. It drives the ALU inputs from registers, captures Result/Zero/Overflow, and returns them over a valid/ready response channel. It also keeps saturating activity and overflow counters for the status readout.

## Interface
- OP_CNT_W, 8: width of completed-command counter
- OVF_CNT_W, 4: width of overflow counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_funct  in  6  funct code
- cmd_a, cmd_b  in  4 each  operands
- alu_a, alu_b  out  4 each  registered operands to the ALU
- alu_op  out  3  registered Operation code to the ALU
- alu_result  in  4  ALU Result
- alu_zero, alu_ovf  in  1 each  ALU Zero and Overflow flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_result  out  4  captured result
- rsp_zero, rsp_ovf, rsp_err  out  1 each  captured flags and illegal-funct/trap error
- op_count  out  OP_CNT_W  saturating count of completed responses
- ovf_count  out  OVF_CNT_W  saturating count of responses with rsp_ovf=1
- ovf_trap  out  1  sticky trap (macro only)
- clear_trap  in  1  clears ovf_trap (macro only)

## Operation
- Funct decode: 100100→AND 000; 100101→OR 001; 100000→ADD 010; 100010→SUB 110; 101010→SLT 111. Every other funct is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1 (0 while ovf_trap=1). On cmd_valid&cmd_ready, latch alu_a/alu_b/alu_op and go to EXEC.
- Illegal funct: the command is still accepted. alu_op is loaded with 000 and the command is marked illegal.
- EXEC: lasts one cycle while the combinational ALU settles. At the end of the cycle, capture into the rsp_* registers, then go to RESP.
- Captured values:
  - rsp_result = alu_result.
  - rsp_zero = alu_zero.
  - rsp_ovf = alu_ovf only for ADD/SUB, otherwise 0.
  - rsp_err = 1 for an illegal funct. For an illegal funct, rsp_result=0000, rsp_zero=0 and rsp_ovf=0.
- RESP: rsp_valid=1 and all rsp_* are held stable until rsp_ready=1. On rsp_valid&rsp_ready, return to IDLE.
- Counters update on the RESP handshake cycle:
  - op_count increments by 1.
  - ovf_count increments by 1 if rsp_ovf=1.
  - Both saturate at all-ones and never wrap.
- alu_a/alu_b/alu_op hold their last values outside EXEC.

## Timing
- Reset values: state=IDLE; cmd_ready=1; rsp_valid=0; every rsp_* = 0; alu_a=alu_b=0000; alu_op=000; op_count=ovf_count=0; ovf_trap=0.
- Latency: a command accepted at edge k gives rsp_valid=1 from edge k+2. With rsp_ready tied high, minimum issue interval is 3 cycles.
- cmd_ready is low in EXEC and RESP. There is no pipelining and only one command is in flight.
- Reset asserted in any state returns the block to reset values at the next edge. An in-flight response is dropped, and counters are not updated.
- Saturated counters hold their value when further increments occur.

## Configuration
- Macro ALU_SEQ_OVF_TRAP_EN.
- Defined:
  - A response with rsp_ovf=1 also sets rsp_err=1 and, on its handshake, sets ovf_trap.
  - While ovf_trap=1, cmd_ready=0.
  - A clear_trap pulse clears ovf_trap at the next edge. If a set and a clear land on the same edge, the set wins.
- Undefined: ovf_trap is tied 0, clear_trap is ignored, and rsp_err reflects illegal funct only.

## Structure
- Package alu_seq_pkg holds: the five funct constants, the Operation encodings (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT), and the FSM state enum.
- One sub-module, alu_funct_decode: combinational, funct in; 3-bit op and legal flag out.
- The ALU itself is not instantiated. The bench connects alu_4bit to the alu_* ports.

## Test plan
- ADD funct 100000, A=0111, B=0001, rsp_ready=1 → rsp_valid at k+2 with result 1000, zero 0, ovf 1, err 0 (err 1 with macro); ovf_count=1.
- SUB funct 100010, A=0011, B=0011 → result 0000, zero 1, ovf 0; op_count increments.
- SLT funct 101010, A=1101, B=0110 → result 0001, rsp_ovf 0. AND 1100/1010 → result 1000, ovf 0 regardless of alu_ovf.
- Illegal funct 000000 → err 1, result 0000, zero 0, alu_op 000; op_count still increments.
- rsp_ready held low 4 cycles → rsp_* stable and cmd_ready 0 throughout. A new cmd_valid is not accepted until the cycle after the handshake.
- rst_n low during EXEC → next edge gives IDLE, rsp_valid 0 and counters unchanged. Also drive 260 ADDs → op_count holds at 255.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the ALU command sequencer.
// Holds the R-type funct codes, the ALU Operation encodings and the
// sequencer FSM state type.
package alu_seq_pkg;

    // R-type funct codes understood by the sequencer
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU Operation encodings
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Sequencer states: one command in flight, no pipelining
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } seq_state_e;

    // Only the arithmetic operations can legitimately report overflow
    function automatic logic op_reports_ovf(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: maps a 6-bit R-type funct onto the 3-bit ALU Operation.
// Unknown funct codes yield OP_AND with legal_o=0 so the ALU inputs stay
// well defined while the command is flagged as illegal.
module alu_funct_decode
    import alu_seq_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] op_o,
    output logic       legal_o
);

    // Pure lookup from funct to Operation code
    always_comb begin
        op_o    = OP_AND;
        legal_o = 1'b1;
        case (funct_i)
            FUNCT_AND: op_o = OP_AND;
            FUNCT_OR:  op_o = OP_OR;
            FUNCT_ADD: op_o = OP_ADD;
            FUNCT_SUB: op_o = OP_SUB;
            FUNCT_SLT: op_o = OP_SLT;
            default: begin
                op_o    = OP_AND;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator-side front end for the 4-bit ALU.
// Accepts R-type commands over valid/ready, drives registered operands and
// Operation code to an external combinational ALU, captures its result one
// cycle later and returns it over a valid/ready response channel. Keeps
// saturating counters of completed responses and of overflowing responses.
// Optional feature, enabled by defining ALU_SEQ_OVF_TRAP_EN: an overflowing
// response is reported as an error and raises a sticky ovf_trap that blocks
// new commands until clear_trap is pulsed.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OP_CNT_W  = 8,
    parameter int OVF_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // command channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [5:0]           cmd_funct,
    input  logic [3:0]           cmd_a,
    input  logic [3:0]           cmd_b,
    // ALU drive and capture
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_op,
    input  logic [3:0]           alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_ovf,
    // response channel
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_ovf,
    output logic                 rsp_err,
    // status
    output logic [OP_CNT_W-1:0]  op_count,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic                 ovf_trap,
    input  logic                 clear_trap
);

    seq_state_e           state_q;
    logic [3:0]           alu_a_q;
    logic [3:0]           alu_b_q;
    logic [2:0]           alu_op_q;
    logic                 illegal_q;
    logic [3:0]           rsp_result_q;
    logic                 rsp_zero_q;
    logic                 rsp_ovf_q;
    logic                 rsp_err_q;
    logic [OP_CNT_W-1:0]  op_cnt_q;
    logic [OVF_CNT_W-1:0] ovf_cnt_q;
    logic                 trap_q;

    logic [2:0]           dec_op;
    logic                 dec_legal;
    logic                 cmd_fire;
    logic                 rsp_fire;
    logic                 exec_ovf_d;
    logic                 exec_err_d;

    alu_funct_decode u_decode (
        .funct_i (cmd_funct),
        .op_o    (dec_op),
        .legal_o (dec_legal)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !trap_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Flags to capture at the end of EXEC; illegal commands never report overflow
    always_comb begin
        exec_ovf_d = !illegal_q && op_reports_ovf(alu_op_q) && alu_ovf;
`ifdef ALU_SEQ_OVF_TRAP_EN
        exec_err_d = illegal_q || exec_ovf_d;
`else
        exec_err_d = illegal_q;
`endif
    end

    // Sequencer FSM, operand/response registers and saturating counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= 4'b0000;
            alu_b_q      <= 4'b0000;
            alu_op_q     <= OP_AND;
            illegal_q    <= 1'b0;
            rsp_result_q <= 4'b0000;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_cnt_q     <= '0;
            ovf_cnt_q    <= '0;
            trap_q       <= 1'b0;
        end else begin
`ifdef ALU_SEQ_OVF_TRAP_EN
            // Clear first so a trap set on the same edge takes precedence
            if (clear_trap) begin
                trap_q <= 1'b0;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        alu_a_q   <= cmd_a;
                        alu_b_q   <= cmd_b;
                        alu_op_q  <= dec_op;
                        illegal_q <= !dec_legal;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU has settled on the registered inputs: capture
                    rsp_result_q <= illegal_q ? 4'b0000 : alu_result;
                    rsp_zero_q   <= illegal_q ? 1'b0 : alu_zero;
                    rsp_ovf_q    <= exec_ovf_d;
                    rsp_err_q    <= exec_err_d;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        if (op_cnt_q != {OP_CNT_W{1'b1}}) begin
                            op_cnt_q <= op_cnt_q + OP_CNT_W'(1);
                        end
                        if (rsp_ovf_q && (ovf_cnt_q != {OVF_CNT_W{1'b1}})) begin
                            ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
                        end
`ifdef ALU_SEQ_OVF_TRAP_EN
                        if (rsp_ovf_q) begin
                            trap_q <= 1'b1;
                        end
`endif
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef ALU_SEQ_OVF_TRAP_EN
    // Trap feature absent: the clear input has no effect
    logic unused_clear_trap;
    assign unused_clear_trap = clear_trap;
`endif

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_cnt_q;
    assign ovf_count  = ovf_cnt_q;
    assign ovf_trap   = trap_q;

endmodule
